// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - command handshake bundle for the shift sequencer
interface shift_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_amount;
    logic [WIDTH-1:0] cmd_data;

    modport master (
        output cmd_valid, cmd_op, cmd_amount, cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_amount, cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - sequences load/rotate/shift commands onto a 4-bit universal shift register
module shift_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clock,
    input  logic             reset_b,
    shift_sequencer_if.slave cmd,
    input  logic [WIDTH-1:0] shifter_q,
    output logic             par_load_n,
    output logic             rot_right,
    output logic             as_right,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

    state_t           r_state;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_hold;
    logic             r_par_load_n;
    logic             r_rot_right;
    logic             r_as_right;
    logic [WIDTH-1:0] r_data_out;
    logic [CNT_W-1:0] r_remaining;

    // The registered control lines double as the latched command fields.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            r_state      <= S_IDLE;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_hold       <= 1'b1;
            r_par_load_n <= 1'b0;
            r_rot_right  <= 1'b0;
            r_as_right   <= 1'b0;
            r_data_out   <= '0;
            r_remaining  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd.cmd_valid) begin
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        if (cmd.cmd_op == 2'b00) begin
                            r_state    <= S_LOAD;
                            r_hold     <= 1'b0;
                            r_data_out <= cmd.cmd_data;
                        end else if (cmd.cmd_amount != '0) begin
                            r_state      <= S_SHIFT;
                            r_hold       <= 1'b0;
                            r_par_load_n <= 1'b1;
                            r_data_out   <= '0;
                            r_rot_right  <= (cmd.cmd_op != 2'b10);
                            r_as_right   <= (cmd.cmd_op == 2'b11);
                            r_remaining  <= cmd.cmd_amount;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    r_state    <= S_DONE;
                    r_done     <= 1'b1;
                    r_hold     <= 1'b1;
                    r_data_out <= '0;
                end
                S_SHIFT: begin
                    r_remaining <= r_remaining - 1'b1;
                    if (r_remaining == 1) begin
                        r_state      <= S_DONE;
                        r_done       <= 1'b1;
                        r_hold       <= 1'b1;
                        r_par_load_n <= 1'b0;
                        r_rot_right  <= 1'b0;
                        r_as_right   <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Hold mode recirculates Q because the register has no enable.
    assign data_out      = r_hold ? shifter_q : r_data_out;
    assign cmd.cmd_ready = r_ready & reset_b;
    assign par_load_n    = r_par_load_n;
    assign rot_right     = r_rot_right;
    assign as_right      = r_as_right;
    assign busy          = r_busy;
    assign done          = r_done;
    assign remaining     = r_remaining;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed self-checking bench for shift_sequencer
module tb_shift_sequencer;
    logic       clock;
    logic       reset_b;
    logic [3:0] shifter_q;
    logic       par_load_n, rot_right, as_right, busy, done;
    logic [3:0] data_out;
    logic [2:0] remaining;
    int         checks;
    int         errors;
    int         done_cnt;

    shift_sequencer_if #(.WIDTH(4), .CNT_W(3)) cmd_if ();

    shift_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
        .clock      (clock),
        .reset_b    (reset_b),
        .cmd        (cmd_if.slave),
        .shifter_q  (shifter_q),
        .par_load_n (par_load_n),
        .rot_right  (rot_right),
        .as_right   (as_right),
        .data_out   (data_out),
        .busy       (busy),
        .done       (done),
        .remaining  (remaining)
    );

    always #5 clock = ~clock;

    // Universal shift register model: no reset, no enable.
    always @(posedge clock) begin
        if (!par_load_n)
            shifter_q <= data_out;
        else if (rot_right && as_right)
            shifter_q <= {shifter_q[3], shifter_q[3:1]};
        else if (rot_right)
            shifter_q <= {shifter_q[0], shifter_q[3:1]};
        else
            shifter_q <= {shifter_q[2:0], shifter_q[3]};
    end

    always @(negedge clock) if (done) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Holds cmd_valid until a handshake edge; returns at accept edge + 1.
    task automatic send(input logic [1:0] op, input logic [2:0] amt, input logic [3:0] data,
                        output int waited);
        int n;
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_op     = op;
        cmd_if.cmd_amount = amt;
        cmd_if.cmd_data   = data;
        n = 0;
        while (!cmd_if.cmd_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) chk("handshake_timeout", 32'(n), 32'd0);
        step();
        waited = n;
        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_op     = ~op;
        cmd_if.cmd_amount = 3'd0;
        cmd_if.cmd_data   = ~data;
    endtask

    task automatic do_load(input logic [3:0] data);
        int w;
        send(2'b00, 3'd0, data, w);
        step();
        step();
    endtask

    initial begin
        int w;
        int bc;
        int d0;
        clock = 1'b0;
        reset_b = 1'b0;
        shifter_q = 4'h0;
        checks = 0;
        errors = 0;
        done_cnt = 0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op = 2'b00;
        cmd_if.cmd_amount = 3'd0;
        cmd_if.cmd_data = 4'h0;

        #12;
        chk("rst_ready", cmd_if.cmd_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_remaining", remaining, 3'd0);
        chk("rst_pln", par_load_n, 1'b0);
        chk("rst_rot", {rot_right, as_right}, 2'b00);
        chk("rst_hold_data", data_out, shifter_q);
        step();
        reset_b = 1'b1;
        #1;
        chk("idle_ready", cmd_if.cmd_ready, 1'b1);

        // Load 1001
        send(2'b00, 3'd5, 4'b1001, w);
        chk("load_pln", par_load_n, 1'b0);
        chk("load_data", data_out, 4'b1001);
        chk("load_busy", busy, 1'b1);
        chk("load_ready", cmd_if.cmd_ready, 1'b0);
        step();
        chk("load_q", shifter_q, 4'b1001);
        chk("load_done", done, 1'b1);
        chk("load_done_ready", cmd_if.cmd_ready, 1'b0);
        step();
        chk("load_done_clr", done, 1'b0);
        chk("load_ready_back", cmd_if.cmd_ready, 1'b1);
        chk("load_done_cnt", done_cnt, 1);
        for (int i = 0; i < 10; i++) step();
        chk("idle_hold_q", shifter_q, 4'b1001);

        // Rotate right by 1
        send(2'b01, 3'd1, 4'hF, w);
        chk("rr1_lines", {par_load_n, rot_right, as_right}, 3'b110);
        chk("rr1_data", data_out, 4'h0);
        chk("rr1_rem", remaining, 3'd1);
        step();
        chk("rr1_rem_end", remaining, 3'd0);
        chk("rr1_done", done, 1'b1);
        chk("rr1_q", shifter_q, 4'b1100);
        step();

        // Rotate left by 3
        do_load(4'b1001);
        send(2'b10, 3'd3, 4'h0, w);
        chk("rl3_lines", {par_load_n, rot_right, as_right}, 3'b100);
        bc = 0;
        for (int i = 0; i < 6; i++) begin
            if (busy) bc++;
            step();
        end
        chk("rl3_busy_cycles", bc, 4);
        chk("rl3_q", shifter_q, 4'b1100);

        // Arithmetic shift right by 2
        do_load(4'b1010);
        send(2'b11, 3'd2, 4'h0, w);
        chk("asr_lines", {par_load_n, rot_right, as_right}, 3'b111);
        step();
        chk("asr_lines2", {par_load_n, rot_right, as_right}, 3'b111);
        step();
        chk("asr_q_1010", shifter_q, 4'b1110);
        step();
        do_load(4'b0110);
        send(2'b11, 3'd2, 4'h0, w);
        step();
        step();
        chk("asr_q_0110", shifter_q, 4'b0001);
        step();

        // Zero-amount rotate, then a command held during busy
        d0 = done_cnt;
        send(2'b01, 3'd0, 4'h0, w);
        chk("z_done", done, 1'b1);
        chk("z_nosh", {par_load_n, remaining}, 4'b0000);
        chk("z_ready", cmd_if.cmd_ready, 1'b0);
        send(2'b10, 3'd1, 4'h0, w);
        chk("held_wait", w, 1);
        chk("z_q", shifter_q, 4'b0001);
        step();
        chk("held_q", shifter_q, 4'b0010);
        step();
        chk("held_done_cnt", done_cnt - d0, 2);

        // Reset in the 3rd cycle of a 7-cycle rotate
        do_load(4'b0011);
        d0 = done_cnt;
        send(2'b01, 3'd7, 4'h0, w);
        step();
        step();
        chk("mid_rem", remaining, 3'd5);
        #2;
        reset_b = 1'b0;
        #1;
        chk("abort_ready", cmd_if.cmd_ready, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_rem", remaining, 3'd0);
        chk("abort_lines", {par_load_n, rot_right, as_right}, 3'b000);
        chk("abort_data", data_out, 4'b1100);
        step();
        step();
        chk("abort_q", shifter_q, 4'b1100);
        #3;
        reset_b = 1'b1;
        step();
        chk("abort_no_done", done_cnt - d0, 0);
        do_load(4'b0101);
        chk("post_q", shifter_q, 4'b0101);
        chk("post_done_cnt", done_cnt - d0, 1);
        chk("post_ready", cmd_if.cmd_ready, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Control stage that sits directly upstream of the 4-bit universal shift register (parallel load / rotate right / rotate left / arithmetic shift right).
- Accepts one command at a time over a valid/ready handshake and drives the register's control lines and load data for the required number of cycles.
- Holds the register contents between commands by reloading its current value, because the register has no enable. Pulses done on completion.

Parameters:
- WIDTH, 4, data width of the downstream shift register.
- CNT_W, 3, width of the shift-amount field; the maximum amount is 2^CNT_W-1.

Ports:
- clock  in  1  rising-edge clock, shared with the shift register.
- reset_b  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  2  00 load, 01 rotate right, 10 rotate left, 11 arithmetic shift right.
- cmd_amount  in  CNT_W  number of shift cycles; ignored for load.
- cmd_data  in  WIDTH  parallel load value; ignored for shifts.
- shifter_q  in  WIDTH  feedback of the shift register's Q.
- par_load_n  out  1  to register ParallelLoadn; 0 = load data_out.
- rot_right  out  1  to register RotateRight; 1 = right, 0 = left.
- as_right  out  1  to register ASRight; 1 = MSB refill on right shift.
- data_out  out  WIDTH  to register Data_IN.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle completion pulse.
- remaining  out  CNT_W  shift cycles still to issue.

Behaviour:
- Reset (reset_b low, asynchronous):
  - State goes to IDLE; latched op, amount and data go to 0.
  - cmd_ready is forced 0 while reset_b is low.
  - busy=0, done=0, remaining=0.
  - Control lines are in hold mode.
- Hold mode, used in IDLE and DONE:
  - par_load_n=0, data_out=shifter_q, rot_right=0, as_right=0.
  - The register reloads its own value, so Q never changes outside LOAD and SHIFT.
- FSM states are IDLE, LOAD, SHIFT, DONE. The FSM is Moore: all outputs decode from registered state, and the only combinational path is data_out = shifter_q in hold mode.
- IDLE:
  - cmd_ready=1.
  - On a clock edge with cmd_valid=1, latch op, amount and data.
  - op=00 goes to LOAD.
  - op≠00 with amount≠0 goes to SHIFT, with remaining=amount.
  - op≠00 with amount=0 goes directly to DONE; no shift occurs.
- LOAD:
  - par_load_n=0, data_out=latched data.
  - Exactly one cycle, then DONE.
- SHIFT:
  - par_load_n=1, data_out=0.
  - Control lines per op:
    - op 01: rot_right=1, as_right=0.
    - op 10: rot_right=0, as_right=0.
    - op 11: rot_right=1, as_right=1.
  - remaining decrements on each edge spent in SHIFT.
  - Leave for DONE on the edge where remaining==1.
  - Exactly `amount` shifting edges occur.
- DONE:
  - Hold mode, done=1, busy=1, cmd_ready=0.
  - One cycle, then IDLE.
- Latency, with the command accepted at edge k:
  - LOAD: the register captures at edge k+1; done is high in the cycle after edge k+1; cmd_ready returns after edge k+2.
  - Shift of N: the register captures at edges k+1..k+N; done is high after edge k+N.
- cmd_valid outside IDLE is ignored; the command is not queued. The bench must hold cmd_valid until a handshake is seen.
- cmd_* inputs are sampled only at the accepting edge; later changes have no effect.
- Maximum amount (2^CNT_W-1) issues that many shifts with no wrap. The remaining counter never underflows.
- Reset mid-LOAD or mid-SHIFT: abort immediately, no done pulse. The register keeps whatever Q it had; there is no rollback.

Test Plan:
- Reset, then load 4'b1001 -> par_load_n=0 for one cycle with data_out=1001; shifter_q=1001; done pulses once; cmd_ready returns 1; Q stays 1001 for 10 idle cycles.
- Rotate right, amount 1, from 1001 -> exactly one SHIFT cycle with rot_right=1, as_right=0; Q=1100; remaining goes 1→0.
- Rotate left, amount 3, from 1001 -> three shift edges with rot_right=0; Q=1100; busy high for 4 cycles including DONE.
- Arithmetic shift right, amount 2, from 1010 -> rot_right=1 and as_right=1 for two cycles; Q=1110. Repeat from 0110 -> Q=0001.
- Amount 0 rotate, then cmd_valid held during busy -> no SHIFT state and Q unchanged; second command accepted only after the IDLE handshake; done counts exactly one per accepted command.
- Assert reset_b low in the 3rd cycle of a 7-cycle rotate -> outputs go to hold/IDLE values asynchronously with cmd_ready=0; no done pulse; after release a fresh load of 0101 completes normally.
